regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regbank_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 96 +++++++++
 tb/tb_regfile_scoreboard.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared constants for the register bank / scoreboard block.
package regbank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // One extra bit so the count can reach DEPTH without wrapping.
  function automatic int busy_cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Register file with write-first bypass and a per-register busy scoreboard
// for issue-time reservations, cleared by writeback.
module regfile_scoreboard
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wa,
  input  logic [DATA_W-1:0]             din,
  input  logic [ADDR_W-1:0]             ra1,
  input  logic [ADDR_W-1:0]             ra2,
  output logic [DATA_W-1:0]             dr1,
  output logic [DATA_W-1:0]             dr2,
  output logic                          busy1,
  output logic                          busy2,
  input  logic                          rsv_en,
  input  logic [ADDR_W-1:0]             rsv_addr,
  output logic                          rsv_ack,
  output logic [busy_cnt_w(ADDR_W)-1:0] busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = busy_cnt_w(ADDR_W);
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  logic wa_zero, ra1_zero, ra2_zero, rsv_zero;
  logic wr_live, bus_clr, bus_set;
  logic hit1, hit2, hit_rsv;

  assign wa_zero  = ZR && (wa == '0);
  assign ra1_zero = ZR && (ra1 == '0);
  assign ra2_zero = ZR && (ra2 == '0);
  assign rsv_zero = ZR && (rsv_addr == '0);

  assign wr_live = wr_en && !wa_zero;
  assign hit1    = wr_live && (wa == ra1);
  assign hit2    = wr_live && (wa == ra2);
  assign hit_rsv = wr_en && (wa == rsv_addr);

  // Reads: hardwired zero first, then same-cycle writeback bypass, then storage.
  always_comb begin
    dr1 = regs[ra1];
    if (ra1_zero)  dr1 = '0;
    else if (hit1) dr1 = din;
    dr2 = regs[ra2];
    if (ra2_zero)  dr2 = '0;
    else if (hit2) dr2 = din;
  end

  assign busy1 = busy[ra1] && !hit1 && !ra1_zero;
  assign busy2 = busy[ra2] && !hit2 && !ra2_zero;

  assign rsv_ack = !rst && rsv_en && (!busy[rsv_addr] || hit_rsv || rsv_zero);

  // Only a writeback that actually retires a busy bit counts as a clear.
  assign bus_clr = wr_live && busy[wa];
  assign bus_set = rsv_ack && !rsv_zero;

  always_comb begin
    busy_nxt = busy;
    if (bus_clr) busy_nxt[wa] = 1'b0;
    if (bus_set) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wa] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      case ({bus_set, bus_clr})
        2'b10:   busy_cnt <= busy_cnt + CNT_W'(1);
        2'b01:   busy_cnt <= busy_cnt - CNT_W'(1);
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one default instance and one with
// register 0 hardwired to zero.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rsv_en;
  logic [AW-1:0] wa, ra1, ra2, rsv_addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dr1, dr2;
  logic          busy1, busy2, rsv_ack;
  logic [AW:0]   busy_cnt;

  logic          zwr_en, zrsv_en;
  logic [AW-1:0] zwa, zra1, zra2, zrsv_addr;
  logic [DW-1:0] zdin;
  logic [DW-1:0] zdr1, zdr2;
  logic          zbusy1, zbusy2, zrsv_ack;
  logic [AW:0]   zbusy_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wa(wa), .din(din),
    .ra1(ra1), .ra2(ra2), .dr1(dr1), .dr2(dr2), .busy1(busy1), .busy2(busy2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(rsv_ack), .busy_cnt(busy_cnt)
  );

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) u_zdut (
    .clk(clk), .rst(rst), .wr_en(zwr_en), .wa(zwa), .din(zdin),
    .ra1(zra1), .ra2(zra2), .dr1(zdr1), .dr2(zdr2), .busy1(zbusy1), .busy2(zbusy2),
    .rsv_en(zrsv_en), .rsv_addr(zrsv_addr), .rsv_ack(zrsv_ack), .busy_cnt(zbusy_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
    wa = '0; din = '0; ra1 = '0; ra2 = '0; rsv_addr = '0;
    zwr_en = 1'b0; zrsv_en = 1'b0;
    zwa = '0; zdin = '0; zra1 = '0; zra2 = '0; zrsv_addr = '0;
    tick();

    // Reservation attempted while reset is high: no ack, discarded.
    rsv_en = 1'b1; rsv_addr = 5'd2; ra1 = 5'd2;
    #1 chk("ack_in_reset", rsv_ack, 1'b0);
    tick();
    rst = 1'b0; rsv_en = 1'b0;
    #1;
    chk("rst_cnt", busy_cnt, 0);
    chk("rst_busy2", busy1, 1'b0);
    chk("rst_dr1", dr1, 0);

    // Plain write, read back next cycle.
    wr_en = 1'b1; wa = 5'd3; din = 32'd100;
    tick();
    wr_en = 1'b0; ra1 = 5'd3;
    #1;
    chk("wr3_dr1", dr1, 32'd100);
    chk("wr3_busy1", busy1, 1'b0);

    // Same-cycle bypass.
    wr_en = 1'b1; wa = 5'd7; din = 32'd7; ra2 = 5'd7;
    #1 chk("bypass_dr2", dr2, 32'd7);
    tick();
    wr_en = 1'b0;
    #1 chk("r7_stored", dr2, 32'd7);

    // Reserve r5, refused second reserve, then writeback.
    rsv_en = 1'b1; rsv_addr = 5'd5; ra1 = 5'd5;
    #1 chk("rsv5_ack", rsv_ack, 1'b1);
    tick();
    chk("rsv5_cnt", busy_cnt, 1);
    chk("rsv5_busy1", busy1, 1'b1);
    chk("rsv5_again_ack", rsv_ack, 1'b0);
    tick();
    chk("rsv5_again_cnt", busy_cnt, 1);
    rsv_en = 1'b0;
    wr_en = 1'b1; wa = 5'd5; din = 32'd752;
    #1;
    chk("wb5_busy1_same", busy1, 1'b0);
    chk("wb5_dr1_same", dr1, 32'd752);
    tick();
    wr_en = 1'b0;
    #1;
    chk("wb5_busy1", busy1, 1'b0);
    chk("wb5_cnt", busy_cnt, 0);
    chk("wb5_dr1", dr1, 32'd752);

    // r9 busy, then writeback and re-reserve of r9 in the same cycle.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    chk("rsv9_cnt", busy_cnt, 1);
    wr_en = 1'b1; wa = 5'd9; din = 32'h99; ra1 = 5'd9;
    #1 chk("wbrsv9_ack", rsv_ack, 1'b1);
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    chk("wbrsv9_busy1", busy1, 1'b1);
    chk("wbrsv9_cnt", busy_cnt, 1);
    chk("wbrsv9_dr1", dr1, 32'h99);

    // Independent reserve r10 and writeback r9 in one cycle.
    wr_en = 1'b1; wa = 5'd9; din = 32'h1234;
    rsv_en = 1'b1; rsv_addr = 5'd10; ra2 = 5'd10;
    #1 chk("indep_ack", rsv_ack, 1'b1);
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    chk("indep_cnt", busy_cnt, 1);
    chk("indep_busy1", busy1, 1'b0);
    chk("indep_busy2", busy2, 1'b1);

    // Writeback to a non-busy register leaves the count alone.
    wr_en = 1'b1; wa = 5'd11; din = 32'hABCD; ra1 = 5'd11;
    tick();
    wr_en = 1'b0;
    #1;
    chk("nb_cnt", busy_cnt, 1);
    chk("nb_dr1", dr1, 32'hABCD);

    // Without ZERO_REG, r0 is an ordinary register.
    wr_en = 1'b1; wa = 5'd0; din = 32'd49; ra1 = 5'd0;
    tick();
    wr_en = 1'b0;
    #1 chk("r0_normal", dr1, 32'd49);

    // ZERO_REG instance: writes to r0 ignored, reserve r0 always granted.
    zwr_en = 1'b1; zwa = 5'd0; zdin = 32'd49; zra1 = 5'd0;
    #1 chk("z_dr1_same", zdr1, 0);
    tick();
    zwr_en = 1'b0;
    #1 chk("z_dr1", zdr1, 0);
    zrsv_en = 1'b1; zrsv_addr = 5'd0;
    #1 chk("z_ack", zrsv_ack, 1'b1);
    tick();
    chk("z_cnt", zbusy_cnt, 0);
    chk("z_busy1", zbusy1, 1'b0);
    chk("z_ack_again", zrsv_ack, 1'b1);
    zrsv_en = 1'b0;

    // Reserve r1, r2, r4 with reset landing on the r4 request.
    rsv_en = 1'b1; rsv_addr = 5'd1;
    tick();
    rsv_addr = 5'd2;
    tick();
    chk("pre_rst_cnt", busy_cnt, 3);
    rsv_addr = 5'd4; rst = 1'b1;
    tick();
    rst = 1'b0; rsv_en = 1'b0; ra1 = 5'd3; ra2 = 5'd10;
    #1;
    chk("mid_rst_cnt", busy_cnt, 0);
    chk("mid_rst_busy2", busy2, 1'b0);
    chk("mid_rst_dr1", dr1, 0);
    chk("mid_rst_dr2", dr2, 0);
    ra1 = 5'd4; ra2 = 5'd1;
    #1;
    chk("mid_rst_busy_r4", busy1, 1'b0);
    chk("mid_rst_busy_r1", busy2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
